decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV64I instruction-decode pipeline stage between IFU and EXU. Accepts {pc, inst}
//  over a valid/ready handshake and decodes the full RV64I base set, including branches,
//  sized loads/stores and the *W word ops. Holds the decoded bundle in a 2-entry
//  (main + skid) buffer so that in_ready never depends combinationally on out_ready.
// PARAMETERS
//  XLEN     64  datapath/immediate width (32 or 64); when 32, LD/SD/LWU/*W decode as illegal
//  ALUOP_W  10  one-hot ALU op width; bits: 0 add,1 sub,2 lt,3 ltu,4 and,5 or,6 xor,7 sll,8 srl,9 sra
// PORTS
//  clk            in   1        clock
//  rst            in   1        asynchronous reset, active-high
//  in_valid       in   1        fetch bundle valid
//  in_ready       out  1        stage can accept a bundle
//  in_pc          in   XLEN     PC of in_inst
//  in_inst        in   32       raw instruction
//  flush          in   1        drop all buffered bundles (redirect)
//  out_valid      out  1        decoded bundle valid
//  out_ready      in   1        EXU accepts bundle
//  out_pc         out  XLEN     PC passed through
//  out_rd/rs1/rs2 out  5 each   register indices (rd forced 0 when reg_wen=0)
//  out_imm        out  XLEN     sign-extended immediate (I/S/B/U/J), 0 for R-type
//  out_alu_op     out  ALUOP_W  one-hot ALU op; all-zero for LUI/ebreak/illegal
//  out_need_imm   out  1        operand 2 is out_imm
//  out_is_word    out  1        *W op: 32-bit operation, sign-extend result
//  out_reg_wen    out  1        writes rd
//  out_mem_wen    out  1        store
//  out_wmask      out  8        byte mask: SB 0x01, SH 0x03, SW 0x0F, SD 0xFF, else 0x00
//  out_is_load    out  1        load
//  out_mem_size   out  2        0 B,1 H,2 W,3 D (loads and stores)
//  out_load_uns   out  1        LBU/LHU/LWU
//  out_is_branch  out  1        conditional branch; out_br_f3 holds funct3
//  out_br_f3      out  3        branch condition
//  out_is_jal/out_is_jalr/out_is_auipc/out_is_lui/out_is_ebreak  out 1 each
//  out_illegal    out  1        unimplemented/reserved encoding
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=1, skid empty; all out_* data fields reset to 0.
//  - Decode is combinational on in_inst; result captured on in_valid&in_ready. Latency 1 cycle.
//  - Main reg drives outputs. Transfer out when out_valid&out_ready.
//  - in_ready = ~skid_valid (registered). If a bundle is accepted while main is full and
//    not draining, it goes to skid. On drain: skid->main if skid full, else new input->main.
//  - Simultaneous accept+drain with skid empty: main loads new bundle, no bubble.
//    Full throughput is 1 bundle/cycle.
//  - Order is strictly preserved; no bundle is duplicated or lost.
//  - flush (synchronous): next cycle out_valid=0, skid empty, in_ready=1. Flush has priority
//    over a same-cycle accept, and the input bundle is discarded.
//  - Immediates: I inst[31:20]; S {31:25,11:7}; B {31,7,30:25,11:8,0}; U {31:12,12'b0};
//    J {31,19:12,20,30:21,0}; all sign-extended to XLEN from inst[31].
//  - SLLI/SRLI/SRAI: shamt = inst[25:20] for XLEN=64 (inst[31:26] 000000/010000);
//    *IW shifts require inst[25]=0, else illegal.
//  - ALU map: add for addi/add/addw/addiw/auipc/loads/stores/jalr; sub for sub/subw;
//    branch compares are resolved in EXU from br_f3, so out_alu_op=0 for branches.
//  - ebreak = 0x00100073 exactly; other SYSTEM encodings, FENCE, bad funct3/funct7 -> illegal.
//  - An illegal bundle still flows with illegal=1 and reg_wen=mem_wen=0.
//  - out_* data is held stable while out_valid&~out_ready.
// TESTING
//  1 0x00500093 (addi x1,x0,5) -> rd=1, imm=5, alu_op=0x001, need_imm=1, reg_wen=1, one cycle later
//  2 0xFE20AE23 (sw x2,-4(x1)) -> mem_wen=1, wmask=0x0F, mem_size=2, imm=0xFFFF_FFFF_FFFF_FFFC, rd=0
//  3 0xFE208EE3 (beq x1,x2,-4) -> is_branch=1, br_f3=0, imm=-4, alu_op=0, reg_wen=0
//  4 Backpressure: stream 4 insts with out_ready low 3 cycles -> in_ready drops after 2 accepted;
//    all 4 emerge in order; no drop or dup
//  5 flush while main+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed bundles never seen
//  6 0x0000100F (fence.i), 0x4000003B (subw illegal funct7 variant 0x4200003B) -> illegal=1; rst mid-stream -> out_valid=0 immediately

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV64I instruction-decode pipeline stage with main+skid output buffer
module decode_stage #(
    parameter int XLEN    = 64,
    parameter int ALUOP_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [31:0]        in_inst,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [XLEN-1:0]    out_imm,
    output logic [ALUOP_W-1:0] out_alu_op,
    output logic               out_need_imm,
    output logic               out_is_word,
    output logic               out_reg_wen,
    output logic               out_mem_wen,
    output logic [7:0]         out_wmask,
    output logic               out_is_load,
    output logic [1:0]         out_mem_size,
    output logic               out_load_uns,
    output logic               out_is_branch,
    output logic [2:0]         out_br_f3,
    output logic               out_is_jal,
    output logic               out_is_jalr,
    output logic               out_is_auipc,
    output logic               out_is_lui,
    output logic               out_is_ebreak,
    output logic               out_illegal
);

    localparam bit RV64 = (XLEN == 64);

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_LT  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_LTU = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(16);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(32);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(64);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(128);
    localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(256);
    localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(512);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPW    = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [XLEN-1:0]    imm;
        logic [ALUOP_W-1:0] alu_op;
        logic               need_imm;
        logic               is_word;
        logic               reg_wen;
        logic               mem_wen;
        logic [7:0]         wmask;
        logic               is_load;
        logic [1:0]         mem_size;
        logic               load_uns;
        logic               is_branch;
        logic [2:0]         br_f3;
        logic               is_jal;
        logic               is_jalr;
        logic               is_auipc;
        logic               is_lui;
        logic               is_ebreak;
        logic               illegal;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // Shift-immediate funct fields: RV64 uses a 6-bit shamt, so only inst[31:26] qualifies the op.
    logic shamt_lo, shamt_ar;
    assign shamt_lo = RV64 ? (in_inst[31:26] == 6'b000000) : (f7 == 7'b0000000);
    assign shamt_ar = RV64 ? (in_inst[31:26] == 6'b010000) : (f7 == 7'b0100000);

    bundle_t dec;
    logic    ill;

    always_comb begin
        dec     = '0;
        ill     = 1'b0;
        dec.pc  = in_pc;
        dec.rs1 = in_inst[19:15];
        dec.rs2 = in_inst[24:20];
        case (opcode)
            OPC_LUI: begin
                dec.imm      = imm_u;
                dec.need_imm = 1'b1;
                dec.reg_wen  = 1'b1;
                dec.is_lui   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm      = imm_u;
                dec.alu_op   = ALU_ADD;
                dec.need_imm = 1'b1;
                dec.reg_wen  = 1'b1;
                dec.is_auipc = 1'b1;
            end
            OPC_JAL: begin
                dec.imm      = imm_j;
                dec.need_imm = 1'b1;
                dec.reg_wen  = 1'b1;
                dec.is_jal   = 1'b1;
            end
            OPC_JALR: begin
                ill          = (f3 != 3'b000);
                dec.imm      = imm_i;
                dec.alu_op   = ALU_ADD;
                dec.need_imm = 1'b1;
                dec.reg_wen  = 1'b1;
                dec.is_jalr  = 1'b1;
            end
            OPC_BRANCH: begin
                ill           = (f3 == 3'b010) || (f3 == 3'b011);
                dec.imm       = imm_b;
                dec.is_branch = 1'b1;
                dec.br_f3     = f3;
            end
            OPC_LOAD: begin
                ill          = (f3 == 3'b111) || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
                dec.imm      = imm_i;
                dec.alu_op   = ALU_ADD;
                dec.need_imm = 1'b1;
                dec.reg_wen  = 1'b1;
                dec.is_load  = 1'b1;
                dec.mem_size = f3[1:0];
                dec.load_uns = f3[2];
            end
            OPC_STORE: begin
                ill          = f3[2] || (!RV64 && f3 == 3'b011);
                dec.imm      = imm_s;
                dec.alu_op   = ALU_ADD;
                dec.need_imm = 1'b1;
                dec.mem_wen  = 1'b1;
                dec.mem_size = f3[1:0];
                case (f3[1:0])
                    2'd0:    dec.wmask = 8'h01;
                    2'd1:    dec.wmask = 8'h03;
                    2'd2:    dec.wmask = 8'h0F;
                    default: dec.wmask = 8'hFF;
                endcase
            end
            OPC_OPIMM: begin
                dec.imm      = imm_i;
                dec.need_imm = 1'b1;
                dec.reg_wen  = 1'b1;
                case (f3)
                    3'b000: dec.alu_op = ALU_ADD;
                    3'b010: dec.alu_op = ALU_LT;
                    3'b011: dec.alu_op = ALU_LTU;
                    3'b100: dec.alu_op = ALU_XOR;
                    3'b110: dec.alu_op = ALU_OR;
                    3'b111: dec.alu_op = ALU_AND;
                    3'b001: begin
                        dec.alu_op = ALU_SLL;
                        ill        = !shamt_lo;
                    end
                    default: begin
                        dec.alu_op = shamt_ar ? ALU_SRA : ALU_SRL;
                        ill        = !(shamt_lo || shamt_ar);
                    end
                endcase
            end
            OPC_OPIMMW: begin
                dec.imm      = imm_i;
                dec.need_imm = 1'b1;
                dec.reg_wen  = 1'b1;
                dec.is_word  = 1'b1;
                case (f3)
                    3'b000: dec.alu_op = ALU_ADD;
                    3'b001: begin
                        dec.alu_op = ALU_SLL;
                        ill        = (f7 != 7'b0000000);
                    end
                    3'b101: begin
                        dec.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                        ill        = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                    end
                    default: ill = 1'b1;
                endcase
                if (!RV64) ill = 1'b1;
            end
            OPC_OP: begin
                dec.reg_wen = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  dec.alu_op = ALU_ADD;
                        3'b001:  dec.alu_op = ALU_SLL;
                        3'b010:  dec.alu_op = ALU_LT;
                        3'b011:  dec.alu_op = ALU_LTU;
                        3'b100:  dec.alu_op = ALU_XOR;
                        3'b101:  dec.alu_op = ALU_SRL;
                        3'b110:  dec.alu_op = ALU_OR;
                        default: dec.alu_op = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dec.alu_op = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    dec.alu_op = ALU_SRA;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_OPW: begin
                dec.reg_wen = 1'b1;
                dec.is_word = 1'b1;
                case ({f7, f3})
                    {7'b0000000, 3'b000}: dec.alu_op = ALU_ADD;
                    {7'b0100000, 3'b000}: dec.alu_op = ALU_SUB;
                    {7'b0000000, 3'b001}: dec.alu_op = ALU_SLL;
                    {7'b0000000, 3'b101}: dec.alu_op = ALU_SRL;
                    {7'b0100000, 3'b101}: dec.alu_op = ALU_SRA;
                    default:              ill = 1'b1;
                endcase
                if (!RV64) ill = 1'b1;
            end
            OPC_SYSTEM: begin
                dec.is_ebreak = (in_inst == 32'h0010_0073);
                ill           = !dec.is_ebreak;
            end
            default: ill = 1'b1;
        endcase
        // Illegal bundles keep only pc and source indices so nothing downstream acts on them.
        if (ill) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.rs1     = in_inst[19:15];
            dec.rs2     = in_inst[24:20];
            dec.illegal = 1'b1;
        end
        dec.rd = dec.reg_wen ? in_inst[11:7] : 5'd0;
    end

    bundle_t main_q, skid_q;
    logic    main_valid, skid_valid;
    logic    accept, drain;

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid & in_ready;
    assign drain     = main_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (drain) begin
            // skid can only be full while in_ready is low, so accept and skid_valid are exclusive here
            if (skid_valid) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q <= dec;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (main_valid) begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end else begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end
        end
    end

    assign out_pc        = main_q.pc;
    assign out_rd        = main_q.rd;
    assign out_rs1       = main_q.rs1;
    assign out_rs2       = main_q.rs2;
    assign out_imm       = main_q.imm;
    assign out_alu_op    = main_q.alu_op;
    assign out_need_imm  = main_q.need_imm;
    assign out_is_word   = main_q.is_word;
    assign out_reg_wen   = main_q.reg_wen;
    assign out_mem_wen   = main_q.mem_wen;
    assign out_wmask     = main_q.wmask;
    assign out_is_load   = main_q.is_load;
    assign out_mem_size  = main_q.mem_size;
    assign out_load_uns  = main_q.load_uns;
    assign out_is_branch = main_q.is_branch;
    assign out_br_f3     = main_q.br_f3;
    assign out_is_jal    = main_q.is_jal;
    assign out_is_jalr   = main_q.is_jalr;
    assign out_is_auipc  = main_q.is_auipc;
    assign out_is_lui    = main_q.is_lui;
    assign out_is_ebreak = main_q.is_ebreak;
    assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - table-driven decode checks plus backpressure/flush/reset sequences
module tb_decode_stage;

    logic        clk, rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [63:0] in_pc, out_pc, out_imm;
    logic [31:0] in_inst;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [9:0]  out_alu_op;
    logic        out_need_imm, out_is_word, out_reg_wen, out_mem_wen, out_is_load;
    logic [7:0]  out_wmask;
    logic [1:0]  out_mem_size;
    logic        out_load_uns, out_is_branch;
    logic [2:0]  out_br_f3;
    logic        out_is_jal, out_is_jalr, out_is_auipc, out_is_lui, out_is_ebreak, out_illegal;

    decode_stage #(.XLEN(64), .ALUOP_W(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_inst(in_inst), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_alu_op(out_alu_op), .out_need_imm(out_need_imm),
        .out_is_word(out_is_word), .out_reg_wen(out_reg_wen), .out_mem_wen(out_mem_wen),
        .out_wmask(out_wmask), .out_is_load(out_is_load), .out_mem_size(out_mem_size),
        .out_load_uns(out_load_uns), .out_is_branch(out_is_branch), .out_br_f3(out_br_f3),
        .out_is_jal(out_is_jal), .out_is_jalr(out_is_jalr), .out_is_auipc(out_is_auipc),
        .out_is_lui(out_is_lui), .out_is_ebreak(out_is_ebreak), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [12:0] ILL = 13'h0001, EBR = 13'h0002, LUI = 13'h0004, AUI = 13'h0008;
    localparam logic [12:0] JALR = 13'h0010, JAL = 13'h0020, BR = 13'h0040, UNS = 13'h0080;
    localparam logic [12:0] LD = 13'h0100, ST = 13'h0200, WEN = 13'h0400, WORD = 13'h0800;
    localparam logic [12:0] IMM = 13'h1000;
    localparam logic [31:0] ADDI = 32'h0050_0093;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [9:0]  alu;
        logic [12:0] flags;
        logic [7:0]  wmask;
        logic [1:0]  size;
        logic [2:0]  f3;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    logic [12:0] act_flags;
    assign act_flags = {out_need_imm, out_is_word, out_reg_wen, out_mem_wen, out_is_load,
                        out_load_uns, out_is_branch, out_is_jal, out_is_jalr, out_is_auipc,
                        out_is_lui, out_is_ebreak, out_illegal};

    // Scoreboard: accepted PCs must emerge in order, exactly once, unless flushed.
    logic        mon_en = 1'b0;
    logic [63:0] exp_q [$];
    int          drained = 0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_out: got pc 0x%0h, expected no bundle", out_pc);
                    end else begin
                        check("order_pc", out_pc, exp_q.pop_front());
                        drained++;
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(in_pc);
            end
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'h0050_0093, 5'd1, 64'd5, 10'h001, IMM|WEN, 8'h00, 2'd0, 3'd0};
        vecs[1]  = '{32'hFE20_AE23, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 10'h001, IMM|ST, 8'h0F, 2'd2, 3'd0};
        vecs[2]  = '{32'hFE20_8EE3, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 10'h000, BR, 8'h00, 2'd0, 3'd0};
        vecs[3]  = '{32'h0020_C463, 5'd0, 64'd8, 10'h000, BR, 8'h00, 2'd0, 3'd4};
        vecs[4]  = '{32'h1234_50B7, 5'd1, 64'h1234_5000, 10'h000, IMM|WEN|LUI, 8'h00, 2'd0, 3'd0};
        vecs[5]  = '{32'h8000_00B7, 5'd1, 64'hFFFF_FFFF_8000_0000, 10'h000, IMM|WEN|LUI, 8'h00, 2'd0, 3'd0};
        vecs[6]  = '{32'h0000_1117, 5'd2, 64'h1000, 10'h001, IMM|WEN|AUI, 8'h00, 2'd0, 3'd0};
        vecs[7]  = '{32'hFFDF_F0EF, 5'd1, 64'hFFFF_FFFF_FFFF_FFFC, 10'h000, IMM|WEN|JAL, 8'h00, 2'd0, 3'd0};
        vecs[8]  = '{32'h0000_8067, 5'd0, 64'd0, 10'h001, IMM|WEN|JALR, 8'h00, 2'd0, 3'd0};
        vecs[9]  = '{32'h0080_B183, 5'd3, 64'd8, 10'h001, IMM|WEN|LD, 8'h00, 2'd3, 3'd0};
        vecs[10] = '{32'hFFF1_4203, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 10'h001, IMM|WEN|LD|UNS, 8'h00, 2'd0, 3'd0};
        vecs[11] = '{32'h0020_B823, 5'd0, 64'd16, 10'h001, IMM|ST, 8'hFF, 2'd3, 3'd0};
        vecs[12] = '{32'h4033_529B, 5'd5, 64'h403, 10'h200, IMM|WEN|WORD, 8'h00, 2'd0, 3'd0};
        vecs[13] = '{32'h0200_109B, 5'd0, 64'd0, 10'h000, ILL, 8'h00, 2'd0, 3'd0};
        vecs[14] = '{32'h43F0_D093, 5'd1, 64'h43F, 10'h200, IMM|WEN, 8'h00, 2'd0, 3'd0};
        vecs[15] = '{32'h4020_81B3, 5'd3, 64'd0, 10'h002, WEN, 8'h00, 2'd0, 3'd0};
        vecs[16] = '{32'h4000_003B, 5'd0, 64'd0, 10'h002, WEN|WORD, 8'h00, 2'd0, 3'd0};
        vecs[17] = '{32'h4200_003B, 5'd0, 64'd0, 10'h000, ILL, 8'h00, 2'd0, 3'd0};
        vecs[18] = '{32'h0000_100F, 5'd0, 64'd0, 10'h000, ILL, 8'h00, 2'd0, 3'd0};
        vecs[19] = '{32'h0010_0073, 5'd0, 64'd0, 10'h000, EBR, 8'h00, 2'd0, 3'd0};
        vecs[20] = '{32'h0000_0073, 5'd0, 64'd0, 10'h000, ILL, 8'h00, 2'd0, 3'd0};
        vecs[21] = '{32'hFFF0_F093, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 10'h010, IMM|WEN, 8'h00, 2'd0, 3'd0};
        vecs[22] = '{32'h0031_30B3, 5'd1, 64'd0, 10'h008, WEN, 8'h00, 2'd0, 3'd0};
        vecs[23] = '{32'h0000_2063, 5'd0, 64'd0, 10'h000, ILL, 8'h00, 2'd0, 3'd0};
        vecs[24] = '{32'h0020_9123, 5'd0, 64'd2, 10'h001, IMM|ST, 8'h03, 2'd1, 3'd0};

        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_pc", out_pc, 64'd0);
        check("reset_out_imm", out_imm, 64'd0);
        check("reset_alu_op", {54'd0, out_alu_op}, 64'd0);
        rst = 1'b0;
        edge1();

        // Back-to-back decode at full throughput.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            in_pc    = 64'h1000 + 64'(4 * i);
            edge1();
            check($sformatf("v%0d_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("v%0d_pc", i), out_pc, 64'h1000 + 64'(4 * i));
            check($sformatf("v%0d_rd", i), {59'd0, out_rd}, {59'd0, vecs[i].rd});
            check($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
            check($sformatf("v%0d_alu", i), {54'd0, out_alu_op}, {54'd0, vecs[i].alu});
            check($sformatf("v%0d_flags", i), {51'd0, act_flags}, {51'd0, vecs[i].flags});
            check($sformatf("v%0d_mem", i), {51'd0, out_wmask, out_mem_size, out_br_f3},
                  {51'd0, vecs[i].wmask, vecs[i].size, vecs[i].f3});
        end
        in_valid = 1'b0;
        edge1();
        check("idle_out_valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: out_ready low for three cycles while four bundles are offered.
        mon_en = 1'b1; drained = 0;
        out_ready = 1'b0; in_valid = 1'b1; in_inst = ADDI; in_pc = 64'h2000;
        edge1();
        check("bp_in_ready_1", {63'd0, in_ready}, 64'd1);
        in_pc = 64'h2004;
        edge1();
        check("bp_in_ready_2", {63'd0, in_ready}, 64'd0);
        check("bp_hold_pc_a", out_pc, 64'h2000);
        in_pc = 64'h2008;
        edge1();
        check("bp_hold_pc_b", out_pc, 64'h2000);
        check("bp_in_ready_3", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        edge1();
        check("bp_skid_to_main", out_pc, 64'h2004);
        check("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
        edge1();
        in_pc = 64'h200C;
        edge1();
        in_valid = 1'b0;
        repeat (3) edge1();
        check("bp_drained", drained, 64'd4);

        // Flush with main+skid full and input valid.
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h3000;
        edge1();
        in_pc = 64'h3004;
        edge1();
        check("fl_full", {62'd0, out_valid, in_ready}, 64'd2);
        in_pc = 64'h3008; flush = 1'b1;
        edge1();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", {63'd0, out_valid}, 64'd0);
        check("fl_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        repeat (3) edge1();

        // Flush beats a same-cycle accept into an empty skid.
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h4000;
        edge1();
        in_pc = 64'h4004; flush = 1'b1;
        edge1();
        flush = 1'b0; in_valid = 1'b0;
        check("fl2_out_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        repeat (2) edge1();
        in_valid = 1'b1; in_pc = 64'h5000;
        edge1();
        in_valid = 1'b0;
        check("post_flush_pc", out_pc, 64'h5000);
        repeat (2) edge1();
        check("total_drained", drained, 64'd5);
        check("queue_empty", exp_q.size(), 64'd0);
        mon_en = 1'b0;

        // Asynchronous reset mid-stream.
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h6000;
        edge1();
        in_pc = 64'h6004;
        edge1();
        #3 rst = 1'b1;
        #1;
        check("rst_async_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_async_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        edge1();
        check("rst_stays_empty", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b1; in_pc = 64'h7000; in_inst = ADDI; out_ready = 1'b1;
        edge1();
        in_valid = 1'b0;
        check("rst_recover_pc", out_pc, 64'h7000);
        check("rst_recover_rd", {59'd0, out_rd}, 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
